// File: rtl/pcie_phy_pkg.sv
// Shared PHY lane constants: ordered-set K symbols and slot types.
// Imported by the per-lane byte serializer.
package pcie_phy_pkg;

   localparam logic [7:0] COM_SYM_C = 8'hBC;
   localparam logic [7:0] IDL_SYM_C = 8'h7C;
   localparam logic [7:0] SKP_SYM_C = 8'h1C;

   typedef enum logic [1:0] {
      SLOT_DATA,
      SLOT_IDLE,
      SLOT_SKP
   } slot_t;

   typedef enum logic {
      ST_START,
      ST_SLOT
   } state_t;

endpackage

// File: rtl/skp_scheduler.sv
// Counts 4-byte slots and flags when the next slot must be a SKP set.
// Ports: clk, reset (sync, high), boundary (slot start), skp_due.
module skp_scheduler #(
   parameter int unsigned SKP_INTERVAL = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic boundary,
   output logic skp_due
);

   logic [7:0] slot_cnt_q;
   logic [7:0] slot_cnt_d;

   assign skp_due = (slot_cnt_q == 8'(SKP_INTERVAL - 1));

   always_comb begin
      slot_cnt_d = slot_cnt_q;
      if (boundary) begin
         slot_cnt_d = skp_due ? 8'd0 : slot_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt_q <= 8'd0;
      end else begin
         slot_cnt_q <= slot_cnt_d;
      end
   end

endmodule

// File: rtl/lane_byte_serializer.sv
// Per-lane serializer: 32-bit word -> 4 bytes, idle/SKP fill, K flag.
// Ports: clk_4f, reset, lane_in/valid_in/ready_out, data_out/k_out/valid_out.
module lane_byte_serializer
   import pcie_phy_pkg::*;
#(
   parameter int unsigned SKP_INTERVAL = 8,
   parameter logic [7:0]  COM_SYM      = COM_SYM_C,
   parameter logic [7:0]  IDL_SYM      = IDL_SYM_C,
   parameter logic [7:0]  SKP_SYM      = SKP_SYM_C
) (
   input  logic        clk_4f,
   input  logic        reset,
   input  logic [31:0] lane_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic [7:0]  data_out,
   output logic        k_out,
   output logic        valid_out
);

   state_t      state_q, state_d;
   slot_t       slot_q, slot_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] hold_q, hold_d;
   logic        hold_full_q, hold_full_d;
   logic [31:0] shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        k_q, k_d;
   logic        valid_q, valid_d;

   logic accept;
   logic boundary;
   logic skp_due;

   assign ready_out = ~reset & ~hold_full_q;
   assign accept    = valid_in & ready_out;
   assign boundary  = ~reset &
                      ((state_q == ST_START) | (byte_cnt_q == 2'd3));

   assign data_out  = data_q;
   assign k_out     = k_q;
   assign valid_out = valid_q;

   skp_scheduler #(
      .SKP_INTERVAL (SKP_INTERVAL)
   ) u_skp (
      .clk      (clk_4f),
      .reset    (reset),
      .boundary (boundary),
      .skp_due  (skp_due)
   );

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      byte_cnt_d  = byte_cnt_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      data_d      = data_q;
      k_d         = k_q;
      valid_d     = valid_q;

      // Accept needs an empty hold; a load needs a full one,
      // so the two never collide on the same edge.
      if (accept) begin
         hold_d      = lane_in;
         hold_full_d = 1'b1;
      end

      if (boundary) begin
         state_d    = ST_SLOT;
         byte_cnt_d = 2'd0;
         valid_d    = 1'b1;
         unique case (1'b1)
            skp_due: begin
               slot_d = SLOT_SKP;
               data_d = COM_SYM;
               k_d    = 1'b1;
            end
            (~skp_due & hold_full_q): begin
               slot_d      = SLOT_DATA;
               shift_d     = {8'h00, hold_q[31:8]};
               hold_full_d = 1'b0;
               data_d      = hold_q[7:0];
               k_d         = 1'b0;
            end
            default: begin
               slot_d = SLOT_IDLE;
               data_d = COM_SYM;
               k_d    = 1'b1;
            end
         endcase
      end else if (state_q == ST_SLOT) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         unique case (slot_q)
            SLOT_DATA: begin
               data_d  = shift_q[7:0];
               shift_d = shift_q >> 8;
            end
            SLOT_SKP: data_d = SKP_SYM;
            default:  data_d = IDL_SYM;
         endcase
      end
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         state_q     <= ST_START;
         slot_q      <= SLOT_IDLE;
         byte_cnt_q  <= 2'd0;
         hold_q      <= 32'h0;
         hold_full_q <= 1'b0;
         shift_q     <= 32'h0;
         data_q      <= 8'h00;
         k_q         <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         byte_cnt_q  <= byte_cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         k_q         <= k_d;
         valid_q     <= valid_d;
      end
   end

endmodule

// File: tb/tb_lane_byte_serializer.sv
// Self-checking bench for lane_byte_serializer.
// Queue-based stream model plus literal slot sequences.
module tb_lane_byte_serializer;

   localparam int SKP_N = 8;

   logic        clk_4f = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] lane_in = 32'h0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [7:0]  data_out;
   logic        k_out;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   lane_byte_serializer #(
      .SKP_INTERVAL (SKP_N)
   ) dut (
      .clk_4f    (clk_4f),
      .reset     (reset),
      .lane_in   (lane_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .k_out     (k_out),
      .valid_out (valid_out)
   );

   always #5 clk_4f = ~clk_4f;

   // Model: accepted words wait in a queue; whenever the byte stream
   // runs dry a whole slot is generated from the priority rules.
   logic [31:0] pending[$];
   logic [8:0]  stream[$];
   int          nslots = 0;
   logic [7:0]  m_data = 8'h00;
   logic        m_k = 1'b0;
   logic        m_valid = 1'b0;

   always @(posedge clk_4f) begin
      logic        rdy;
      logic [31:0] w;
      logic [8:0]  e;
      if (reset) begin
         pending.delete();
         stream.delete();
         nslots  = 0;
         m_data  = 8'h00;
         m_k     = 1'b0;
         m_valid = 1'b0;
      end else begin
         rdy = (pending.size() == 0);
         if (stream.size() == 0) begin
            if ((nslots % SKP_N) == SKP_N - 1) begin
               stream.push_back({1'b1, 8'hBC});
               for (int i = 0; i < 3; i++) stream.push_back({1'b1, 8'h1C});
            end else if (pending.size() > 0) begin
               w = pending.pop_front();
               for (int i = 0; i < 4; i++)
                  stream.push_back({1'b0, w[8*i +: 8]});
            end else begin
               stream.push_back({1'b1, 8'hBC});
               for (int i = 0; i < 3; i++) stream.push_back({1'b1, 8'h7C});
            end
            nslots++;
         end
         e = stream.pop_front();
         m_k     = e[8];
         m_data  = e[7:0];
         m_valid = 1'b1;
         if (valid_in && rdy) pending.push_back(lane_in);
      end
   end

   // Per-cycle compare plus capture of valid output bytes.
   logic       cap_en = 1'b0;
   logic [9:0] cap[$];
   logic [9:0] exp_q[$];

   always @(negedge clk_4f) begin
      logic [10:0] act, exv;
      act = {ready_out, valid_out, k_out, data_out};
      exv = {~reset & (pending.size() == 0), m_valid, m_k, m_data};
      checks++;
      if (act !== exv) begin
         errors++;
         $display("FAIL model t=%0t act rdy/v/k/d=%h req=%h",
                  $time, act, exv);
      end
      if (cap_en && valid_out) cap.push_back({valid_out, k_out, data_out});
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exv);
      checks++;
      if (act !== exv) begin
         errors++;
         $display("FAIL %s act=%h req=%h", nm, act, exv);
      end
   endtask

   task automatic tick();
      @(posedge clk_4f);
      #2;
   endtask

   task automatic add_idle();
      exp_q.push_back({2'b11, 8'hBC});
      for (int i = 0; i < 3; i++) exp_q.push_back({2'b11, 8'h7C});
   endtask

   task automatic add_skp();
      exp_q.push_back({2'b11, 8'hBC});
      for (int i = 0; i < 3; i++) exp_q.push_back({2'b11, 8'h1C});
   endtask

   task automatic add_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) exp_q.push_back({2'b10, w[8*i +: 8]});
   endtask

   task automatic wait_cap(input int n);
      int t;
      t = 0;
      while (cap.size() < n && t < 200) begin
         @(negedge clk_4f);
         t++;
      end
      #1;
   endtask

   task automatic cmp_cap(input string nm);
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= cap.size()) begin
            errors++;
            $display("FAIL %s[%0d] act=none req=%h", nm, i, exp_q[i]);
         end else if (cap[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL %s[%0d] act=%h req=%h", nm, i, cap[i], exp_q[i]);
         end
      end
      exp_q.delete();
   endtask

   task automatic do_reset();
      cap_en   = 1'b0;
      reset    = 1'b1;
      valid_in = 1'b0;
      repeat (3) tick();
      @(negedge clk_4f);
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_kv", {30'h0, k_out, valid_out}, 32'h0);
      chk("rst_ready", 32'(ready_out), 32'h0);
      tick();
      reset = 1'b0;
      cap.delete();
      cap_en = 1'b1;
   endtask

   task automatic send(input logic [31:0] w);
      int   n;
      logic r;
      valid_in = 1'b1;
      lane_in  = w;
      n = 0;
      do begin
         @(negedge clk_4f);
         r = ready_out;
         tick();
         n++;
      end while (!r && n < 30);
      checks++;
      if (!r) begin
         errors++;
         $display("FAIL send_timeout act=not_ready req=ready w=%h", w);
      end
      valid_in = 1'b0;
   endtask

   initial begin
      logic [31:0] w;
      int          n;

      // Idle after reset
      do_reset();
      repeat (2) add_idle();
      wait_cap(8);
      cmp_cap("idle");

      // Single word
      do_reset();
      send(32'hDDCCBBAA);
      add_idle();
      add_word(32'hDDCCBBAA);
      add_idle();
      wait_cap(12);
      cmp_cap("single");

      // Back-to-back words
      do_reset();
      send(32'h03020100);
      send(32'h07060504);
      send(32'h0B0A0908);
      add_idle();
      add_word(32'h03020100);
      add_word(32'h07060504);
      add_word(32'h0B0A0908);
      add_idle();
      wait_cap(20);
      cmp_cap("b2b");

      // Forced SKP in slot 7 of continuous data
      do_reset();
      for (int i = 0; i < 8; i++) begin
         w = 32'h40404040 + {4{8'(4 * i)}} + 32'h03020100;
         send(w);
      end
      add_idle();
      for (int i = 0; i < 6; i++)
         add_word(32'h40404040 + {4{8'(4 * i)}} + 32'h03020100);
      add_skp();
      add_word(32'h40404040 + {4{8'(24)}} + 32'h03020100);
      add_word(32'h40404040 + {4{8'(28)}} + 32'h03020100);
      wait_cap(40);
      cmp_cap("skp");

      // Reset during byte 2 of a data slot, word in hold
      do_reset();
      send(32'h11223344);
      send(32'h55667788);
      tick();
      reset = 1'b1;
      @(negedge clk_4f);
      chk("midrst_ready", 32'(ready_out), 32'h0);
      chk("midrst_byte2", 32'(data_out), 32'h22);
      @(posedge clk_4f);
      @(negedge clk_4f);
      chk("midrst_data", 32'(data_out), 32'h0);
      chk("midrst_valid", 32'(valid_out), 32'h0);
      tick();
      reset = 1'b0;
      cap.delete();
      repeat (3) add_idle();
      wait_cap(12);
      cmp_cap("midrst");

      // Changing lane_in while stalled
      do_reset();
      send(32'hA3A2A1A0);
      valid_in = 1'b1;
      n = 0;
      do begin
         lane_in = 32'hE0E1E200 + 32'(n);
         @(negedge clk_4f);
         w = lane_in;
         if (ready_out) break;
         tick();
         n++;
      end while (n < 30);
      tick();
      valid_in = 1'b0;
      add_idle();
      add_word(32'hA3A2A1A0);
      add_word(32'hE0E1E204);
      add_idle();
      wait_cap(16);
      cmp_cap("stall");
      chk("stall_word", w, 32'hE0E1E204);

      cap_en = 1'b0;
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
